// File: rtl/alu_share_arbiter_pkg.sv
// Shared ALU parameters: control-code width, the opcodes the ALU decodes, and the
// output-slot state type used by alu_share_arbiter.
package alu_share_arbiter_pkg;

    localparam int unsigned ALU_CTRL_W = 6;
    localparam int unsigned DATA_W     = 32;

    // The arbiter only routes these codes; the ALU is the only consumer that decodes them.
    localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = 6'h00;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = 6'h01;
    localparam logic [ALU_CTRL_W-1:0] ALU_AND  = 6'h02;
    localparam logic [ALU_CTRL_W-1:0] ALU_OR   = 6'h03;
    localparam logic [ALU_CTRL_W-1:0] ALU_XOR  = 6'h04;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLL  = 6'h05;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT  = 6'h06;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLTU = 6'h07;
    localparam logic [ALU_CTRL_W-1:0] ALU_SRL  = 6'h08;
    localparam logic [ALU_CTRL_W-1:0] ALU_SRA  = 6'h09;

    typedef enum logic [0:0] {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-input round-robin arbiter: one-hot grant plus the next priority pointer.
// The pointer only moves when both inputs competed; it then points at the loser.
module rr_arb2 (
    input  logic       i_en,
    input  logic       i_valid0,
    input  logic       i_valid1,
    input  logic       i_ptr,
    output logic [1:0] o_grant,
    output logic       o_ptr_next
);

    always_comb begin
        o_grant    = '0;
        o_ptr_next = i_ptr;
        if (i_en) begin
            if (i_valid0 && i_valid1) begin
                o_grant    = i_ptr ? 2'b10 : 2'b01;
                o_ptr_next = ~i_ptr;
            end else if (i_valid0) begin
                o_grant = 2'b01;
            end else if (i_valid1) begin
                o_grant = 2'b10;
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Time-shares one combinational ALU between two requesters and buffers one response.
// Optional perf counters are enabled by defining ALU_ARB_PERF_EN.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [ALU_CTRL_W-1:0] req0_op,
    input  logic [DATA_W-1:0]     req0_a,
    input  logic [DATA_W-1:0]     req0_b,
    input  logic [TAG_W-1:0]      req0_tag,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [ALU_CTRL_W-1:0] req1_op,
    input  logic [DATA_W-1:0]     req1_a,
    input  logic [DATA_W-1:0]     req1_b,
    input  logic [TAG_W-1:0]      req1_tag,
    output logic [DATA_W-1:0]     alu_a,
    output logic [DATA_W-1:0]     alu_b,
    output logic [ALU_CTRL_W-1:0] alu_ctrl,
    input  logic [DATA_W-1:0]     alu_result,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_src,
    output logic [TAG_W-1:0]      rsp_tag,
    output logic [DATA_W-1:0]     rsp_data
`ifdef ALU_ARB_PERF_EN
    ,
    output logic [15:0]           perf_grant0,
    output logic [15:0]           perf_grant1,
    output logic [15:0]           perf_conflict
`endif
);

    slot_state_t         r_state;
    slot_state_t         w_state_nxt;
    logic                r_ptr;
    logic                w_ptr_nxt;
    logic                w_slot_free;
    logic                w_arb_en;
    logic [1:0]          w_grant;
    logic                r_rsp_src;
    logic [TAG_W-1:0]    r_rsp_tag;
    logic [DATA_W-1:0]   r_rsp_data;

    assign rsp_valid   = (r_state == SLOT_FULL);
    assign rsp_src     = r_rsp_src;
    assign rsp_tag     = r_rsp_tag;
    assign rsp_data    = r_rsp_data;
    assign w_slot_free = !rsp_valid || rsp_ready;
    // Reset blocks arbitration so nothing is accepted in a reset cycle.
    assign w_arb_en    = w_slot_free && !reset;
    assign req0_ready  = w_grant[0];
    assign req1_ready  = w_grant[1];

    rr_arb2 u_arb (
        .i_en       (w_arb_en),
        .i_valid0   (req0_valid),
        .i_valid1   (req1_valid),
        .i_ptr      (r_ptr),
        .o_grant    (w_grant),
        .o_ptr_next (w_ptr_nxt)
    );

    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_ctrl = '0;
        if (w_grant[0]) begin
            alu_a    = req0_a;
            alu_b    = req0_b;
            alu_ctrl = req0_op;
        end else if (w_grant[1]) begin
            alu_a    = req1_a;
            alu_b    = req1_b;
            alu_ctrl = req1_op;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SLOT_EMPTY: if (|w_grant) w_state_nxt = SLOT_FULL;
            SLOT_FULL:  if (rsp_ready) w_state_nxt = (|w_grant) ? SLOT_FULL : SLOT_EMPTY;
            default:    w_state_nxt = SLOT_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= SLOT_EMPTY;
            r_ptr      <= 1'b0;
            r_rsp_src  <= 1'b0;
            r_rsp_tag  <= '0;
            r_rsp_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            if (|w_grant) begin
                r_rsp_data <= alu_result;
                r_rsp_src  <= w_grant[1];
                r_rsp_tag  <= w_grant[1] ? req1_tag : req0_tag;
            end
        end
    end

`ifdef ALU_ARB_PERF_EN
    logic [15:0] r_perf_grant0;
    logic [15:0] r_perf_grant1;
    logic [15:0] r_perf_conflict;

    assign perf_grant0   = r_perf_grant0;
    assign perf_grant1   = r_perf_grant1;
    assign perf_conflict = r_perf_conflict;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_grant0   <= '0;
            r_perf_grant1   <= '0;
            r_perf_conflict <= '0;
        end else begin
            if (w_grant[0] && r_perf_grant0 != 16'hFFFF)
                r_perf_grant0 <= r_perf_grant0 + 16'd1;
            if (w_grant[1] && r_perf_grant1 != 16'hFFFF)
                r_perf_grant1 <= r_perf_grant1 + 16'd1;
            if (req0_valid && req1_valid && w_slot_free && r_perf_conflict != 16'hFFFF)
                r_perf_conflict <= r_perf_conflict + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter with a behavioural ALU model.
// Perf-counter checks are compiled only when ALU_ARB_PERF_EN is defined.
module tb_alu_share_arbiter;
    import alu_share_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [5:0]  req0_op, req1_op, alu_ctrl;
    logic [31:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b, alu_result, rsp_data;
    logic [3:0]  req0_tag, req1_tag, rsp_tag;
    logic        rsp_valid, rsp_ready, rsp_src;
`ifdef ALU_ARB_PERF_EN
    logic [15:0] perf_grant0, perf_grant1, perf_conflict;
`endif

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    always_comb begin
        alu_result = '0;
        case (alu_ctrl)
            ALU_ADD:  alu_result = alu_a + alu_b;
            ALU_SUB:  alu_result = alu_a - alu_b;
            ALU_AND:  alu_result = alu_a & alu_b;
            ALU_OR:   alu_result = alu_a | alu_b;
            ALU_XOR:  alu_result = alu_a ^ alu_b;
            ALU_SLL:  alu_result = alu_a << alu_b[4:0];
            ALU_SLT:  alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
            ALU_SLTU: alu_result = {31'd0, alu_a < alu_b};
            ALU_SRL:  alu_result = alu_a >> alu_b[4:0];
            ALU_SRA:  alu_result = $unsigned($signed(alu_a) >>> alu_b[4:0]);
            default:  alu_result = '0;
        endcase
    end

    alu_share_arbiter #(.TAG_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_tag   (req0_tag),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_tag   (req1_tag),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_src    (rsp_src),
        .rsp_tag    (rsp_tag),
        .rsp_data   (rsp_data)
`ifdef ALU_ARB_PERF_EN
        ,
        .perf_grant0   (perf_grant0),
        .perf_grant1   (perf_grant1),
        .perf_conflict (perf_conflict)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just past the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_op = ALU_ADD; req0_a = 32'd1; req0_b = 32'd1; req0_tag = 4'd1;
        req1_valid = 1'b0; req1_op = ALU_ADD; req1_a = '0;    req1_b = '0;    req1_tag = '0;
        tick(); tick();
        check("rst_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_data", rsp_data, 32'd0);
        check("rst_src", {31'd0, rsp_src}, 32'd0);
        check("rst_tag", {28'd0, rsp_tag}, 32'd0);
        check("rst_ready0", {31'd0, req0_ready}, 32'd0);

        // Single requester 0: 5 + 7 with tag 3.
        reset = 1'b0;
        req0_op = ALU_ADD; req0_a = 32'd5; req0_b = 32'd7; req0_tag = 4'd3;
        #1;
        check("add_ready0", {31'd0, req0_ready}, 32'd1);
        check("add_alu_a", alu_a, 32'd5);
        check("add_ctrl", {26'd0, alu_ctrl}, {26'd0, ALU_ADD});
        tick();
        req0_valid = 1'b0;
        #1;
        check("add_valid", {31'd0, rsp_valid}, 32'd1);
        check("add_data", rsp_data, 32'd12);
        check("add_src", {31'd0, rsp_src}, 32'd0);
        check("add_tag", {28'd0, rsp_tag}, 32'd3);
        check("idle_alu_a", alu_a, 32'd0);
        check("idle_ctrl", {26'd0, alu_ctrl}, 32'd0);
        rsp_ready = 1'b1;
        tick();
        check("drain_valid", {31'd0, rsp_valid}, 32'd0);

        // Both valid for 4 cycles: alternating grants, back-to-back responses.
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_op = ALU_ADD; req1_op = ALU_SUB;
        for (int k = 0; k < 4; k++) begin
            req0_a = 32'd10 + k; req0_b = 32'd1;  req0_tag = 4'(k);
            req1_a = 32'd100;    req1_b = 32'(k); req1_tag = 4'(8 + k);
            #1;
            check("rr_ready0", {31'd0, req0_ready}, {31'd0, k % 2 == 0});
            check("rr_ready1", {31'd0, req1_ready}, {31'd0, k % 2 == 1});
            tick();
            check("rr_valid", {31'd0, rsp_valid}, 32'd1);
            check("rr_src", {31'd0, rsp_src}, 32'(k % 2));
            check("rr_data", rsp_data, (k % 2 == 0) ? 32'd11 + k : 32'd100 - k);
            check("rr_tag", {28'd0, rsp_tag}, (k % 2 == 0) ? 32'(k) : 32'(8 + k));
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        check("rr_drain", {31'd0, rsp_valid}, 32'd0);

        // Backpressure: slot held FULL while req1 waits, then drain and grant together.
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_op = ALU_ADD; req0_a = 32'd20; req0_b = 32'd22; req0_tag = 4'd5;
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_op = ALU_XOR; req1_a = 32'h0000_FF00; req1_b = 32'h0000_0FF0; req1_tag = 4'd9;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_ready1", {31'd0, req1_ready}, 32'd0);
            tick();
            check("bp_valid", {31'd0, rsp_valid}, 32'd1);
            check("bp_data", rsp_data, 32'd42);
            check("bp_tag", {28'd0, rsp_tag}, 32'd5);
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_release_ready1", {31'd0, req1_ready}, 32'd1);
        tick();
        req1_valid = 1'b0;
        check("bp_new_valid", {31'd0, rsp_valid}, 32'd1);
        check("bp_new_data", rsp_data, 32'h0000_F0F0);
        check("bp_new_src", {31'd0, rsp_src}, 32'd1);
        check("bp_new_tag", {28'd0, rsp_tag}, 32'd9);
        tick();

        // Arithmetic shift via requester 1 is passed through untouched.
        req1_valid = 1'b1; req1_op = ALU_SRA; req1_a = 32'h8000_0010; req1_b = 32'd4; req1_tag = 4'd6;
        tick();
        req1_valid = 1'b0;
        check("sra_data", rsp_data, 32'hF800_0001);
        check("sra_src", {31'd0, rsp_src}, 32'd1);
        tick();

        // Conflict grant moves ptr to 1, then reset while FULL and both valid.
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_op = ALU_ADD; req0_a = 32'd1; req0_b = 32'd2; req0_tag = 4'd2;
        req1_op = ALU_ADD; req1_a = 32'd3; req1_b = 32'd4; req1_tag = 4'd4;
        tick();
        check("pre_rst_src", {31'd0, rsp_src}, 32'd0);
        reset = 1'b1;
        #1;
        check("rst_mid_ready0", {31'd0, req0_ready}, 32'd0);
        check("rst_mid_ready1", {31'd0, req1_ready}, 32'd0);
        tick();
        check("rst_mid_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_mid_data", rsp_data, 32'd0);
        reset = 1'b0;
        #1;
        check("post_rst_ready0", {31'd0, req0_ready}, 32'd1);
        check("post_rst_ready1", {31'd0, req1_ready}, 32'd0);
        tick();
        check("post_rst_src", {31'd0, rsp_src}, 32'd0);
        check("post_rst_data", rsp_data, 32'd3);

`ifdef ALU_ARB_PERF_EN
        reset = 1'b1;
        tick();
        check("perf_rst_g0", {16'd0, perf_grant0}, 32'd0);
        check("perf_rst_cf", {16'd0, perf_conflict}, 32'd0);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        req1_valid = 1'b0;
        tick(); tick();
        req0_valid = 1'b0;
        check("perf_g0", {16'd0, perf_grant0}, 32'd4);
        check("perf_g1", {16'd0, perf_grant1}, 32'd1);
        check("perf_cf", {16'd0, perf_conflict}, 32'd3);
`endif

        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
